// File: rtl/denoise_dispatch.sv
// Denoise front end: a one-entry registered slice that steers each 4-block beat to the
// median or gaussian engine, with the engine choice latched once per frame.
module denoise_dispatch #(
  parameter int BITWIDTH        = 8,
  parameter int BEATS_PER_FRAME = 1024,
  parameter int CNT_W           = $clog2(BEATS_PER_FRAME + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  frame_start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITWIDTH*9-1:0] block_in_0,
  input  logic [BITWIDTH*9-1:0] block_in_1,
  input  logic [BITWIDTH*9-1:0] block_in_2,
  input  logic [BITWIDTH*9-1:0] block_in_3,
  output logic                  M_valid,
  input  logic                  M_ready,
  output logic [BITWIDTH*9-1:0] M_block_out_0,
  output logic [BITWIDTH*9-1:0] M_block_out_1,
  output logic [BITWIDTH*9-1:0] M_block_out_2,
  output logic [BITWIDTH*9-1:0] M_block_out_3,
  output logic                  G_valid,
  input  logic                  G_ready,
  output logic [BITWIDTH*9-1:0] G_block_out_0,
  output logic [BITWIDTH*9-1:0] G_block_out_1,
  output logic [BITWIDTH*9-1:0] G_block_out_2,
  output logic [BITWIDTH*9-1:0] G_block_out_3,
  output logic                  mode_active,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int               BLK_W    = BITWIDTH * 9;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS_PER_FRAME);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e                 state_q, state_d;
  logic                   full_q, full_d;
  logic                   mode_active_q, mode_active_d;
  logic                   frame_done_q, frame_done_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3:0][BLK_W-1:0]  data_q, data_d;

  logic sel_ready;
  logic accept;
  logic drain;

  // Downstream ready passes straight through so a full slice can refill in the same cycle.
  assign sel_ready = mode_active_q ? G_ready : M_ready;
  assign in_ready  = (state_q == S_RUN) && (!full_q || sel_ready);
  assign accept    = in_valid && in_ready;
  assign drain     = full_q && sel_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    state_d       = state_q;
    full_d        = full_q;
    data_d        = data_q;
    mode_active_d = mode_active_q;
    cnt_d         = cnt_q;
    frame_done_d  = 1'b0;

    if (accept) begin
      full_d = 1'b1;
      data_d = {block_in_3, block_in_2, block_in_1, block_in_0};
    end else if (drain) begin
      full_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d       = S_RUN;
          mode_active_d = mode;
          cnt_d         = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (cnt_q != LAST_CNT) cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT - CNT_ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!full_q || drain) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      full_q        <= 1'b0;
      mode_active_q <= 1'b0;
      frame_done_q  <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      mode_active_q <= mode_active_d;
      frame_done_q  <= frame_done_d;
      cnt_q         <= cnt_d;
    end
  end

  // NOTE: the payload register is not reset; it is only ever observed while full_q is set.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign M_valid       = full_q && !mode_active_q;
  assign G_valid       = full_q && mode_active_q;
  assign M_block_out_0 = M_valid ? data_q[0] : '0;
  assign M_block_out_1 = M_valid ? data_q[1] : '0;
  assign M_block_out_2 = M_valid ? data_q[2] : '0;
  assign M_block_out_3 = M_valid ? data_q[3] : '0;
  assign G_block_out_0 = G_valid ? data_q[0] : '0;
  assign G_block_out_1 = G_valid ? data_q[1] : '0;
  assign G_block_out_2 = G_valid ? data_q[2] : '0;
  assign G_block_out_3 = G_valid ? data_q[3] : '0;
  assign mode_active   = mode_active_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_denoise_dispatch.sv
// Directed bench for denoise_dispatch with a 4-beat frame: a cycle table for two full frames
// plus hand sequences for mid-frame reset and a gapped input stream.
module tb_denoise_dispatch;

  localparam int BW    = 8;
  localparam int BLK_W = BW * 9;

  logic             clk, rst;
  logic             mode, frame_start, in_valid, in_ready;
  logic [BLK_W-1:0] block_in_0, block_in_1, block_in_2, block_in_3;
  logic             M_valid, M_ready, G_valid, G_ready;
  logic [BLK_W-1:0] M_block_out_0, M_block_out_1, M_block_out_2, M_block_out_3;
  logic [BLK_W-1:0] G_block_out_0, G_block_out_1, G_block_out_2, G_block_out_3;
  logic             mode_active, busy, frame_done;

  int n_cmp  = 0;
  int n_fail = 0;

  denoise_dispatch #(.BITWIDTH(BW), .BEATS_PER_FRAME(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready),
    .block_in_0(block_in_0), .block_in_1(block_in_1),
    .block_in_2(block_in_2), .block_in_3(block_in_3),
    .M_valid(M_valid), .M_ready(M_ready),
    .M_block_out_0(M_block_out_0), .M_block_out_1(M_block_out_1),
    .M_block_out_2(M_block_out_2), .M_block_out_3(M_block_out_3),
    .G_valid(G_valid), .G_ready(G_ready),
    .G_block_out_0(G_block_out_0), .G_block_out_1(G_block_out_1),
    .G_block_out_2(G_block_out_2), .G_block_out_3(G_block_out_3),
    .mode_active(mode_active), .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Block k of a beat tagged t is the byte (t+k) replicated over all nine pixels; tag 0 = zeros.
  function automatic logic [BLK_W-1:0] blk(input logic [7:0] tag, input int k);
    logic [7:0] b;
    if (tag == 8'h00) return '0;
    b = tag + 8'(k);
    return {9{b}};
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkb(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fs, input logic md, input logic iv,
                       input logic mr, input logic gr, input logic [7:0] tag);
    frame_start = fs;
    mode        = md;
    in_valid    = iv;
    M_ready     = mr;
    G_ready     = gr;
    block_in_0  = blk(tag, 0);
    block_in_1  = blk(tag, 1);
    block_in_2  = blk(tag, 2);
    block_in_3  = blk(tag, 3);
  endtask

  typedef struct {
    logic       fs, md, iv, mr, gr;
    logic [7:0] tag;
    logic       ir, mv, gv, ma, bz, fd;
    logic [7:0] mtag, gtag;
  } vec_t;

  function automatic vec_t v(input logic fs, md, iv, mr, gr, input logic [7:0] tag,
                             input logic ir, mv, gv, ma, bz, fd, input logic [7:0] mtag, gtag);
    vec_t r;
    r.fs = fs; r.md = md; r.iv = iv; r.mr = mr; r.gr = gr; r.tag = tag;
    r.ir = ir; r.mv = mv; r.gv = gv; r.ma = ma; r.bz = bz; r.fd = fd;
    r.mtag = mtag; r.gtag = gtag;
    return r;
  endfunction

  vec_t vecs[20];

  initial begin
    logic [7:0] exp_q[$];
    logic [7:0] exp_tag;
    int         accepts, fd_cnt, gv_cnt;

    //                fs md iv mr gr tag    ir mv gv ma bz fd mtag   gtag
    // Frame A: median, 4 beats back to back, extra beat offered during drain.
    vecs[0]  = v(1, 0, 0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[1]  = v(0, 0, 1, 1, 1, 8'h10, 1, 0, 0, 0, 1, 0, 8'h00, 8'h00);
    vecs[2]  = v(0, 0, 1, 1, 1, 8'h20, 1, 1, 0, 0, 1, 0, 8'h10, 8'h00);
    vecs[3]  = v(0, 0, 1, 1, 1, 8'h30, 1, 1, 0, 0, 1, 0, 8'h20, 8'h00);
    vecs[4]  = v(0, 0, 1, 1, 1, 8'h40, 1, 1, 0, 0, 1, 0, 8'h30, 8'h00);
    vecs[5]  = v(0, 0, 1, 1, 1, 8'h50, 0, 1, 0, 0, 1, 0, 8'h40, 8'h00);
    vecs[6]  = v(0, 0, 1, 1, 1, 8'h50, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    vecs[7]  = v(0, 0, 0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    // Frame B: gaussian, G_ready toggling, mode/frame_start noise in RUN and DRAIN.
    vecs[8]  = v(1, 1, 0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    vecs[9]  = v(0, 1, 1, 1, 1, 8'h11, 1, 0, 0, 1, 1, 0, 8'h00, 8'h00);
    vecs[10] = v(0, 0, 1, 1, 0, 8'h22, 0, 0, 1, 1, 1, 0, 8'h00, 8'h11);
    vecs[11] = v(0, 1, 1, 1, 1, 8'h22, 1, 0, 1, 1, 1, 0, 8'h00, 8'h11);
    vecs[12] = v(1, 0, 1, 1, 0, 8'h33, 0, 0, 1, 1, 1, 0, 8'h00, 8'h22);
    vecs[13] = v(0, 1, 1, 1, 1, 8'h33, 1, 0, 1, 1, 1, 0, 8'h00, 8'h22);
    vecs[14] = v(0, 0, 1, 1, 0, 8'h44, 0, 0, 1, 1, 1, 0, 8'h00, 8'h33);
    vecs[15] = v(0, 1, 1, 1, 1, 8'h44, 1, 0, 1, 1, 1, 0, 8'h00, 8'h33);
    vecs[16] = v(1, 0, 0, 1, 0, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 8'h44);
    vecs[17] = v(0, 1, 0, 1, 1, 8'h00, 0, 0, 1, 1, 1, 0, 8'h00, 8'h44);
    vecs[18] = v(0, 0, 0, 1, 1, 8'h00, 0, 0, 0, 1, 0, 1, 8'h00, 8'h00);
    vecs[19] = v(0, 0, 0, 1, 1, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00);

    // Reset held with busy-looking inputs: everything must read 0.
    rst = 1'b1;
    drive(1, 1, 1, 1, 1, 8'h01);
    repeat (2) @(negedge clk);
    #1;
    check1("rst in_ready", in_ready, 1'b0);
    check1("rst M_valid", M_valid, 1'b0);
    check1("rst G_valid", G_valid, 1'b0);
    check1("rst mode_active", mode_active, 1'b0);
    check1("rst busy", busy, 1'b0);
    check1("rst frame_done", frame_done, 1'b0);
    checkb("rst M_block_out_0", M_block_out_0, '0);
    checkb("rst G_block_out_0", G_block_out_0, '0);
    drive(0, 0, 0, 1, 1, 8'h00);
    rst = 1'b0;

    // Start a gaussian frame, park one beat in the slice, then reset mid-cycle.
    @(negedge clk); drive(1, 1, 0, 1, 0, 8'h00); #1;
    check1("mid idle in_ready", in_ready, 1'b0);
    @(negedge clk); drive(0, 0, 1, 1, 0, 8'h55); #1;
    check1("mid run in_ready", in_ready, 1'b1);
    check1("mid run mode_active", mode_active, 1'b1);
    @(negedge clk); drive(0, 0, 0, 1, 0, 8'h00); #1;
    check1("mid full G_valid", G_valid, 1'b1);
    checkb("mid full G_block_out_0", G_block_out_0, blk(8'h55, 0));
    #1 rst = 1'b1;
    #1;
    check1("async rst in_ready", in_ready, 1'b0);
    check1("async rst G_valid", G_valid, 1'b0);
    checkb("async rst G_block_out_0", G_block_out_0, '0);
    check1("async rst mode_active", mode_active, 1'b0);
    check1("async rst busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 1, 1, 1, 8'h66); #1;
    check1("post rst in_ready", in_ready, 1'b0);
    check1("post rst busy", busy, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      check1($sformatf("post rst c%0d frame_done", c), frame_done, 1'b0);
      check1($sformatf("post rst c%0d G_valid", c), G_valid, 1'b0);
    end

    // Cycle table: inputs applied on the falling edge, outputs compared 1 time unit later.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i].fs, vecs[i].md, vecs[i].iv, vecs[i].mr, vecs[i].gr, vecs[i].tag);
      #1;
      check1($sformatf("row%0d in_ready", i), in_ready, vecs[i].ir);
      check1($sformatf("row%0d M_valid", i), M_valid, vecs[i].mv);
      check1($sformatf("row%0d G_valid", i), G_valid, vecs[i].gv);
      check1($sformatf("row%0d mode_active", i), mode_active, vecs[i].ma);
      check1($sformatf("row%0d busy", i), busy, vecs[i].bz);
      check1($sformatf("row%0d frame_done", i), frame_done, vecs[i].fd);
      checkb($sformatf("row%0d M_block_out_0", i), M_block_out_0, blk(vecs[i].mtag, 0));
      checkb($sformatf("row%0d M_block_out_1", i), M_block_out_1, blk(vecs[i].mtag, 1));
      checkb($sformatf("row%0d M_block_out_2", i), M_block_out_2, blk(vecs[i].mtag, 2));
      checkb($sformatf("row%0d M_block_out_3", i), M_block_out_3, blk(vecs[i].mtag, 3));
      checkb($sformatf("row%0d G_block_out_0", i), G_block_out_0, blk(vecs[i].gtag, 0));
      checkb($sformatf("row%0d G_block_out_1", i), G_block_out_1, blk(vecs[i].gtag, 1));
      checkb($sformatf("row%0d G_block_out_2", i), G_block_out_2, blk(vecs[i].gtag, 2));
      checkb($sformatf("row%0d G_block_out_3", i), G_block_out_3, blk(vecs[i].gtag, 3));
    end

    // Median frame after a gaussian one, beats offered every other cycle, more than a frame's worth.
    @(negedge clk); drive(1, 0, 0, 1, 1, 8'h00);
    @(negedge clk); drive(0, 1, 0, 1, 1, 8'h00); #1;
    check1("gap mode_active relatched", mode_active, 1'b0);
    accepts = 0; fd_cnt = 0; gv_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive(0, c[0], (c % 2 == 0), 1, 0, 8'h60 + 8'(accepts * 4));
      #1;
      if (M_valid && M_ready) begin
        exp_tag = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        checkb($sformatf("gap c%0d M_block_out_0", c), M_block_out_0, blk(exp_tag, 0));
        checkb($sformatf("gap c%0d M_block_out_3", c), M_block_out_3, blk(exp_tag, 3));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(8'h60 + 8'(accepts * 4));
        accepts++;
      end
      if (frame_done) fd_cnt++;
      if (G_valid) gv_cnt++;
    end
    check1("gap accepted beats == 4", accepts == 4, 1'b1);
    check1("gap frame_done pulses == 1", fd_cnt == 1, 1'b1);
    check1("gap G_valid never seen", gv_cnt == 0, 1'b1);
    check1("gap all beats delivered", exp_q.size() == 0, 1'b1);
    check1("gap ends idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
